// File: rtl/sig_record_play.sv
// Record/playback engine: captures a burst of samples into an internal buffer,
// then streams them back out one-shot or looped, paced by the sample strobe.
module sig_record_play #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  rec_start,
  input  logic                  play_start,
  input  logic                  abort,
  input  logic                  loop,
  input  logic [ADDR_WIDTH-1:0] rec_len,
  input  logic [WIDTH-1:0]      mic_signal,
  output logic [WIDTH-1:0]      play_signal,
  output logic                  play_valid,
  output logic                  rec_done,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   stored_len,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECORD   = 2'd1,
    PLAYBACK = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wrAddr;
  logic [ADDR_WIDTH-1:0] r_rdAddr;
  logic [ADDR_WIDTH:0]   r_target;
  logic [ADDR_WIDTH:0]   r_storedLen;
  logic [WIDTH-1:0]      r_playSignal;
  logic                  r_playValid;
  logic                  r_recDone;

  logic w_startRec;
  logic w_startPlay;
  logic w_write;
  logic w_recFinish;
  logic w_recAbort;
  logic w_issue;
  logic w_readWrap;
  logic w_recLast;
  logic w_playLast;

  // Pointers are widened to length width so a DEPTH-long target compares cleanly.
  assign w_recLast  = ({1'b0, r_wrAddr} == (r_target - (ADDR_WIDTH+1)'(1)));
  assign w_playLast = ({1'b0, r_rdAddr} == (r_storedLen - (ADDR_WIDTH+1)'(1)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_startRec  = 1'b0;
    w_startPlay = 1'b0;
    w_write     = 1'b0;
    w_recFinish = 1'b0;
    w_recAbort  = 1'b0;
    w_issue     = 1'b0;
    w_readWrap  = 1'b0;
    case (r_state)
      IDLE: begin
        if (rec_start) begin
          w_startRec  = 1'b1;
          w_nextState = RECORD;
        end else if (play_start && (r_storedLen != '0)) begin
          w_startPlay = 1'b1;
          w_nextState = PLAYBACK;
        end
      end
      RECORD: begin
        w_write = en;
        // A final write coinciding with abort still counts as a normal finish.
        if (en && w_recLast) begin
          w_recFinish = 1'b1;
          w_nextState = IDLE;
        end else if (abort) begin
          w_recAbort  = 1'b1;
          w_nextState = IDLE;
        end
      end
      PLAYBACK: begin
        w_issue    = en;
        w_readWrap = en && w_playLast && loop;
        if (abort) begin
          w_nextState = IDLE;
        end else if (en && w_playLast && !loop) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wrAddr] <= mic_signal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wrAddr     <= '0;
      r_rdAddr     <= '0;
      r_target     <= '0;
      r_storedLen  <= '0;
      r_playSignal <= '0;
      r_playValid  <= 1'b0;
      r_recDone    <= 1'b0;
    end else begin
      r_recDone   <= w_recFinish;
      r_playValid <= w_issue;
      if (w_issue) begin
        r_playSignal <= r_mem[r_rdAddr];
      end

      if (w_startRec) begin
        r_target    <= (rec_len == '0) ? DEPTH_LEN : {1'b0, rec_len};
        r_wrAddr    <= '0;
        r_storedLen <= '0;
      end else if (w_write) begin
        r_wrAddr <= r_wrAddr + ADDR_WIDTH'(1);
      end

      if (w_recFinish) begin
        r_storedLen <= r_target;
      end else if (w_recAbort) begin
        r_storedLen <= {1'b0, r_wrAddr} + (ADDR_WIDTH+1)'(w_write);
      end

      if (w_startPlay || w_readWrap) begin
        r_rdAddr <= '0;
      end else if (w_issue) begin
        r_rdAddr <= r_rdAddr + ADDR_WIDTH'(1);
      end
    end
  end

  assign play_signal = r_playSignal;
  assign play_valid  = r_playValid;
  assign rec_done    = r_recDone;
  assign busy        = (r_state != IDLE);
  assign stored_len  = r_storedLen;
  assign wr_addr     = r_wrAddr;
  assign rd_addr     = r_rdAddr;

endmodule
